// File: rtl/ip_forward_sched.sv
// ip_forward_sched
//   Sequences one fully-connected layer through the pipelined ip_forward
//   dot-product datapath. Every (neuron, tile) pair is requested from the
//   operand fetch stage in order. Each issue is tracked through a fixed-latency
//   shadow pipe, and the partial result is captured into a first-word-fall-through
//   result FIFO. Issue is gated by credits, so a captured result always finds
//   room in the FIFO.
//
//   Ports
//     clk, reset (async, active-low)
//     start, num_tiles, num_out        layer kick-off and configuration
//     busy, done                       layer status
//     op_req, op_neuron, op_tile       operand tile request
//     op_ack                           issue = op_req & op_ack
//     dp_in_id                         issue sequence number to datapath
//     dp_out_data                      datapath result, LATENCY cycles after issue
//     res_valid, res_ready, res_data,  result stream (pop = res_valid & res_ready)
//     res_neuron, res_last
//
//   Optional build macro IP_FWD_SCHED_ID_CHECK_EN adds dp_out_id and id_err.
//   This sticky flag reports when a returned tag does not match the tag
//   that was issued.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start (busy still high during the done cycle)
//   RUN   | issuing (neuron, tile) pairs, gated by credits
//   DRAIN | all pairs issued; waiting for pipe and FIFO to empty
module ip_forward_sched #(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 28,
  parameter int CNT_W      = 10,
  parameter int FIFO_DEPTH = 32,
  parameter int IDW        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tiles,
  input  logic [CNT_W-1:0] num_out,
  output logic             busy,
  output logic             done,
  output logic             op_req,
  output logic [CNT_W-1:0] op_neuron,
  output logic [CNT_W-1:0] op_tile,
  input  logic             op_ack,
  output logic [IDW-1:0]   dp_in_id,
  input  logic [31:0]      dp_out_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [CNT_W-1:0] res_neuron,
  output logic             res_last
`ifdef IP_FWD_SCHED_ID_CHECK_EN
  ,
  input  logic [IDW-1:0]   dp_out_id,
  output logic             id_err
`endif
);

  if (WIDTH < 1 || LATENCY < 1 || FIFO_DEPTH < 1) begin : g_bad_param
    $error("ip_forward_sched: WIDTH, LATENCY and FIFO_DEPTH must all be >= 1");
  end

  localparam int CW = $clog2(LATENCY + FIFO_DEPTH + 1) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = 32 + CNT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cfg_tiles;
  logic [CNT_W-1:0] cfg_out;
  logic [CW-1:0]    inflight;
  logic [CW-1:0]    fifo_cnt;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]    head;

  logic             pipe_v [LATENCY];
  logic [CNT_W-1:0] pipe_n [LATENCY];
  logic             pipe_l [LATENCY];

  logic issue, capture, pop, accept, tile_last, last_pair, drain_fin;

  // Credits cover both in-flight issues and buffered results, so the FIFO
  // always has room for every capture.
  assign op_req    = (state == S_RUN) && ((inflight + fifo_cnt) < CW'(FIFO_DEPTH));
  assign issue     = op_req & op_ack;
  assign capture   = pipe_v[LATENCY-1];
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid & res_ready;
  assign accept    = start && (state == S_IDLE) && !busy;
  assign tile_last = (op_tile == cfg_tiles - CNT_W'(1));
  assign last_pair = tile_last && (op_neuron == cfg_out - CNT_W'(1));
  // Finish on the edge that removes the final result, so done follows the
  // last pop directly. A push cannot happen here because nothing is in flight.
  assign drain_fin = (inflight == '0) &&
                     ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_tiles <= '0;
      cfg_out   <= '0;
      op_neuron <= '0;
      op_tile   <= '0;
      dp_in_id  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            cfg_tiles <= num_tiles;
            cfg_out   <= num_out;
            op_neuron <= '0;
            op_tile   <= '0;
            dp_in_id  <= '0;
            busy      <= 1'b1;
            // An empty layer completes immediately.
            if (num_tiles == '0 || num_out == '0) begin
              done <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            dp_in_id <= dp_in_id + IDW'(1);
            if (tile_last) begin
              op_tile   <= '0;
              op_neuron <= op_neuron + CNT_W'(1);
            end else begin
              op_tile <= op_tile + CNT_W'(1);
            end
            if (last_pair) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_fin) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      case ({issue, capture})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Shadow of the datapath pipeline: stage LATENCY-1 lines up with dp_out_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_n[i] <= '0;
        pipe_l[i] <= 1'b0;
      end
    end else begin
      pipe_v[0] <= issue;
      pipe_n[0] <= op_neuron;
      pipe_l[0] <= tile_last;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_n[i] <= pipe_n[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (capture) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      if (pop)     rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      case ({capture, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) fifo_mem[wr_ptr] <= {dp_out_data, pipe_n[LATENCY-1], pipe_l[LATENCY-1]};
  end

  assign head       = fifo_mem[rd_ptr];
  assign res_data   = res_valid ? head[EW-1:CNT_W+1] : '0;
  assign res_neuron = res_valid ? head[CNT_W:1]      : '0;
  assign res_last   = res_valid ? head[0]            : 1'b0;

`ifdef IP_FWD_SCHED_ID_CHECK_EN
  logic [IDW-1:0] pipe_id [LATENCY];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) pipe_id[i] <= '0;
    end else begin
      pipe_id[0] <= dp_in_id;
      for (int i = 1; i < LATENCY; i++) pipe_id[i] <= pipe_id[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_err <= 1'b0;
    end else if (accept) begin
      id_err <= 1'b0;
    end else if (capture && (dp_out_id != pipe_id[LATENCY-1])) begin
      id_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ip_forward_sched.sv
// Directed bench for ip_forward_sched: a behavioural datapath returns
// enc(neuron, tile) exactly LAT cycles after each issue. Each result popped
// from the DUT is checked against the (neuron, tile) order the bench expects.
module tb_ip_forward_sched;
  localparam int LAT   = 28;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  num_tiles, num_out;
  logic        busy, done, op_req, op_ack;
  logic [9:0]  op_neuron, op_tile;
  logic [7:0]  dp_in_id;
  logic [31:0] dp_out_data;
  logic        res_valid, res_ready, res_last;
  logic [31:0] res_data;
  logic [9:0]  res_neuron;
`ifdef IP_FWD_SCHED_ID_CHECK_EN
  logic [7:0]  dp_out_id;
  logic        id_err;
  logic        corrupt_en;
  logic [7:0]  id_pipe [LAT];
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  ip_forward_sched #(.WIDTH(8), .LATENCY(LAT), .CNT_W(10), .FIFO_DEPTH(DEPTH), .IDW(8)) dut (
    .clk(clk), .reset(rst_n), .start(start), .num_tiles(num_tiles), .num_out(num_out),
    .busy(busy), .done(done), .op_req(op_req), .op_neuron(op_neuron), .op_tile(op_tile),
    .op_ack(op_ack), .dp_in_id(dp_in_id), .dp_out_data(dp_out_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_neuron(res_neuron), .res_last(res_last)
`ifdef IP_FWD_SCHED_ID_CHECK_EN
    , .dp_out_id(dp_out_id), .id_err(id_err)
`endif
  );

  function automatic logic [31:0] enc(input logic [9:0] n, input logic [9:0] t);
    return {6'd0, n, 6'd0, t};
  endfunction

  // Behavioural datapath
  logic [31:0] dp_pipe [LAT];
  logic        dpv     [LAT];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        dpv[i]     <= 1'b0;
        dp_pipe[i] <= '0;
      end
    end else begin
      dpv[0]     <= op_req & op_ack;
      dp_pipe[0] <= enc(op_neuron, op_tile);
      for (int i = 1; i < LAT; i++) begin
        dpv[i]     <= dpv[i-1];
        dp_pipe[i] <= dp_pipe[i-1];
      end
    end
  end

  assign dp_out_data = dpv[LAT-1] ? dp_pipe[LAT-1] : 32'hDEAD_BEEF;

`ifdef IP_FWD_SCHED_ID_CHECK_EN
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) id_pipe[i] <= '0;
    end else begin
      id_pipe[0] <= dp_in_id;
      for (int i = 1; i < LAT; i++) id_pipe[i] <= id_pipe[i-1];
    end
  end
  // Corrupt the tag returned with the third result (neuron 0, tile 2).
  assign dp_out_id = id_pipe[LAT-1] ^
                     ((corrupt_en && dpv[LAT-1] && dp_pipe[LAT-1] == enc(10'd0, 10'd2)) ? 8'h01 : 8'h00);
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic kick(input int n_out, input int n_tiles);
    num_out   = 10'(n_out);
    num_tiles = 10'(n_tiles);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic pop_check(input int n_out, input int n_tiles, input bit chk_id);
    for (int k = 0; k < n_out * n_tiles; k++) begin
      int b;
      b = 0;
      while (!res_valid && b < 300) begin
        step();
        b++;
      end
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_data", res_data, enc(10'(k / n_tiles), 10'(k % n_tiles)));
      chk("res_neuron", 32'(res_neuron), 32'(k / n_tiles));
      chk("res_last", 32'(res_last), 32'((k % n_tiles) == n_tiles - 1));
`ifdef IP_FWD_SCHED_ID_CHECK_EN
      if (chk_id) chk("id_err_seq", 32'(id_err), 32'(k >= 2));
`else
      if (chk_id) chk("id_chk_unused", 32'(res_valid), 32'd1);
`endif
      step();
    end
    chk("done_after_last_pop", 32'(done), 32'd1);
    chk("busy_with_done", 32'(busy), 32'd1);
    chk("res_valid_empty", 32'(res_valid), 32'd0);
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_dropped", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, b, iss;
    rst_n = 1'b0; start = 1'b0; num_tiles = '0; num_out = '0;
    op_ack = 1'b0; res_ready = 1'b0;
`ifdef IP_FWD_SCHED_ID_CHECK_EN
    corrupt_en = 1'b0;
`endif
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op_req", 32'(op_req), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_dp_in_id", 32'(dp_in_id), 32'd0);
    chk("rst_op_neuron", 32'(op_neuron), 32'd0);
    chk("rst_op_tile", 32'(op_tile), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_neuron", 32'(res_neuron), 32'd0);
    chk("rst_res_last", 32'(res_last), 32'd0);
`ifdef IP_FWD_SCHED_ID_CHECK_EN
    chk("rst_id_err", 32'(id_err), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // 1: 3 neurons x 2 tiles, back-to-back issue, latency, ordering, done timing
    op_ack = 1'b1; res_ready = 1'b1;
    kick(3, 2);
    t0 = 0;
    for (int k = 0; k < 6; k++) begin
      chk("t1_op_req", 32'(op_req), 32'd1);
      chk("t1_op_neuron", 32'(op_neuron), 32'(k / 2));
      chk("t1_op_tile", 32'(op_tile), 32'(k % 2));
      chk("t1_dp_in_id", 32'(dp_in_id), 32'(k));
      step();
      if (k == 0) t0 = cyc;
    end
    chk("t1_op_req_off", 32'(op_req), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    b = 0;
    while (!res_valid && b < 100) begin
      step();
      b++;
    end
    chk("t1_first_valid_latency", 32'(cyc - t0), 32'(LAT));
    pop_check(3, 2, 1'b0);

    // 2: downstream stalled -> credits cap issue at FIFO depth, then release
    res_ready = 1'b0;
    kick(40, 1);
    iss = 0;
    for (int c = 0; c < 60; c++) begin
      if (op_req && op_ack) iss++;
      step();
    end
    chk("t2_issues_capped", 32'(iss), 32'(DEPTH));
    chk("t2_op_req_blocked", 32'(op_req), 32'd0);
    chk("t2_fifo_head_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    pop_check(40, 1, 1'b0);

    // 3: empty layer
    kick(5, 0);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_op_req", 32'(op_req), 32'd0);
    step();
    chk("t3_done_end", 32'(done), 32'd0);
    chk("t3_busy_end", 32'(busy), 32'd0);
    chk("t3_no_issue", 32'(op_req), 32'd0);

    // 4: op_ack toggling holds operands; start during RUN ignored
    kick(2, 3);
    iss = 0;
    for (int c = 0; c < 20 && iss < 6; c++) begin
      op_ack = (c % 2 == 0);
      if (c == 1) begin
        start = 1'b1; num_out = 10'd7; num_tiles = 10'd1;
      end else begin
        start = 1'b0;
      end
      chk("t4_op_req", 32'(op_req), 32'd1);
      chk("t4_op_neuron", 32'(op_neuron), 32'(iss / 3));
      chk("t4_op_tile", 32'(op_tile), 32'(iss % 3));
      chk("t4_dp_in_id", 32'(dp_in_id), 32'(iss));
      step();
      if (op_ack) iss++;
    end
    start = 1'b0; op_ack = 1'b1;
    chk("t4_issue_count", 32'(iss), 32'd6);
    chk("t4_op_req_off", 32'(op_req), 32'd0);
    pop_check(2, 3, 1'b0);

    // 5: reset mid-layer, then a clean layer with no stale results
    kick(4, 4);
    for (int c = 0; c < 10; c++) step();
    chk("t5_pre_rst_id", 32'(dp_in_id), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_op_req", 32'(op_req), 32'd0);
    chk("t5_rst_dp_in_id", 32'(dp_in_id), 32'd0);
    chk("t5_rst_op_neuron", 32'(op_neuron), 32'd0);
    chk("t5_rst_op_tile", 32'(op_tile), 32'd0);
    chk("t5_rst_res_valid", 32'(res_valid), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    step(); step(); step();
    rst_n = 1'b1;
    step();
    kick(4, 4);
    pop_check(4, 4, 1'b0);

`ifdef IP_FWD_SCHED_ID_CHECK_EN
    // 6: corrupted tag on third result sets sticky id_err, next start clears it
    corrupt_en = 1'b1;
    kick(1, 4);
    chk("t6_id_err_clear", 32'(id_err), 32'd0);
    pop_check(1, 4, 1'b1);
    chk("t6_id_err_sticky", 32'(id_err), 32'd1);
    corrupt_en = 1'b0;
    kick(0, 0);
    chk("t6_id_err_cleared_by_start", 32'(id_err), 32'd0);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
